fetch_queue: RTL
================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-register fetch/decode handoff with a decoupled prefetch queue. It issues sequential PCs to the BIOS and IMEM synchronous-read memories and routes each return by PC region. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO. The FIFO is presented to decode through a valid/ready handshake and is flushed on a redirect from branch/jump resolution.

Parameters:
DEPTH, 4, FIFO entries; legal range 2..16; DEPTH>=3 sustains 1 inst/cycle
BIOS_AW, 12, BIOS word-address width
IMEM_AW, 14, IMEM word-address width
RESET_PC, 32'h4000_0000, fetch PC after reset
REGION_BIT, 30, PC bit selecting BIOS (1) or IMEM (0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bios_en  out  1  BIOS read enable
bios_addr  out  BIOS_AW  BIOS word address, pc[BIOS_AW+1:2]
bios_dout  in  32  BIOS read data, valid 1 cycle after request
imem_en  out  1  IMEM read enable
imem_addr  out  IMEM_AW  IMEM word address, pc[IMEM_AW+1:2]
imem_dout  in  32  IMEM read data, valid 1 cycle after request
redirect  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_inst  out  32  head instruction
out_pc  out  32  head PC
count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high and overrides all other inputs.
- Reset values: fetch_pc=RESET_PC, FIFO empty, count=0, in-flight=0, out_valid=0, bios_en=imem_en=0.
- Reset outputs: out_inst=32'h0000_0013 (NOP) and out_pc=0 while the FIFO is empty.
- Issue condition: a request is issued in a cycle when !rst && !redirect && (count + inflight) < DEPTH.
  - count is the start-of-cycle occupancy; a same-cycle pop does not free a credit.
  - inflight is 0 or 1.
- Issue action: fetch_pc[REGION_BIT]=1 raises bios_en, else imem_en; exactly one enable is high.
  - Both addresses are always driven from fetch_pc.
  - fetch_pc <= fetch_pc+4 (32-bit wrap).
  - The region bit and PC are recorded for the in-flight slot.
- Return: one cycle after issue, data is muxed from the recorded region and pushed as {inst, pc} at that cycle's edge. It is visible on out_* the following cycle.
- Latency: request issued in cycle N gives out_valid=1 in cycle N+2. The first request is the first cycle after rst deasserts.
- Handshake: pop occurs when out_valid && out_ready. out_valid = (count!=0) && !redirect.
  - out_inst/out_pc must hold stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged, and order is preserved.
- Full FIFO: no issue. The credit rule guarantees no push into a full FIFO; a push into a full FIFO is an assertion failure.
- Redirect in cycle N:
  - FIFO is cleared and count=0 at the edge.
  - Any pop that cycle is ignored.
  - A read in flight from cycle N-1 is discarded when it returns.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No request is issued in cycle N; the first new request is in N+1 and the new out_valid is in N+3.
- Back-to-back redirects: the last one wins, and every intermediate in-flight read is discarded.
- Reset mid-operation: same as reset; in-flight data is discarded.
- Region crossing: a sequential PC crossing REGION_BIT switches the memory with no bubble.

Test Plan:
1. Reset release, RESET_PC=4000_0000, out_ready=1, BIOS words 0..3 = A0..A3 -> bios_en from cycle 0; out_valid from cycle 2; out_pc 4000_0000, _0004, _0008 with insts A0, A1, A2 on consecutive cycles.
2. out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4; no enable while full; head stays 4000_0000/A0; releasing ready gives 4 pops then streaming resumes at 4000_0010 with no gap or duplicate.
3. redirect=1 with redirect_pc=0000_0103 while FIFO holds 3 entries and a read is in flight -> count=0 next cycle; imem_en with addr 0x40 in N+1; out_pc=0000_0100 in N+3; no stale entry ever appears.
4. Redirect and pop in the same cycle, followed by a redirect on the next cycle to 0000_0200 -> only the 0000_0200 stream emerges, first at N+4.
5. Sequential fetch across 3FFF_FFFC -> 4000_0000 -> imem_en then bios_en on consecutive cycles; outputs in order with correct insts.
6. rst asserted mid-stream with count=3 -> next cycle count=0, out_valid=0; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetch queue. It issues sequential PCs to BIOS or IMEM
// by PC region, buffers {inst, pc} returns in a DEPTH-entry FIFO, and flushes on redirect.
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter int          BIOS_AW    = 12,
  parameter int          IMEM_AW    = 14,
  parameter logic [31:0] RESET_PC   = 32'h4000_0000,
  parameter int          REGION_BIT = 30,
  localparam int         CW         = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               bios_en,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic [CW-1:0]      count
);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc, infl_pc, ret_inst;
  logic          inflight, infl_bios;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          issue, push, pop, empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check: entries held plus the one read in flight must leave room.
  // A pop in the same cycle does not free a credit.
  assign issue = !rst && !redirect &&
                 (({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH));

  assign bios_en   = issue &&  fetch_pc[REGION_BIT];
  assign imem_en   = issue && !fetch_pc[REGION_BIT];
  assign bios_addr = fetch_pc[BIOS_AW+1:2];
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign ret_inst  = infl_bios ? bios_dout : imem_dout;
  assign push      = inflight && !redirect;
  assign empty     = (count == '0);
  assign out_valid = !empty && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_inst  = empty ? NOP   : q_inst[rd_ptr];
  assign out_pc    = empty ? 32'h0 : q_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      inflight  <= 1'b0;
      infl_bios <= 1'b0;
      infl_pc   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (redirect) begin
      // Clearing inflight drops the read returning this cycle or next.
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_bios <= fetch_pc[REGION_BIT];
        infl_pc   <= fetch_pc;
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_inst[wr_ptr] <= ret_inst;
      q_pc[wr_ptr]   <= infl_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (count != CW'(DEPTH));
  end
endmodule
